// File: rtl/bsram_pkg.sv
// Shared types and sizes for the word-to-byte BSRAM port controller.
package bsram_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    RESP
  } state_t;

endpackage

// File: rtl/bsram_word_port_if.sv
// Word request/response bus between the core data path and the BSRAM port controller.
interface bsram_word_port_if #(
  parameter int ADDR_W = 11
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/bsram_word_port.sv
// Splits 32-bit word requests into four byte accesses on an 8-bit single-port BSRAM,
// assembling reads little-endian and applying byte strobes on writes.
module bsram_word_port
  import bsram_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               resetn,
  bsram_word_port_if.slave   bus,
  output logic               mem_ce,
  output logic               mem_oce,
  output logic               mem_wre,
  output logic               mem_reset,
  output logic [ADDR_W-1:0]  mem_ad,
  output logic [7:0]         mem_din,
  input  logic [7:0]         mem_dout
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  if (RD_LAT != 1) begin : g_bad_rd_lat
    $error("bsram_word_port: only RD_LAT = 1 is supported");
  end

  state_t                         state_q, state_d;
  logic [BYTE_IDX_W-1:0]          cnt_q;
  logic                           we_q;
  logic [ADDR_W-1:BYTE_IDX_W]     addr_q;
  logic [31:0]                    wdata_q;
  logic [3:0]                     wstrb_q;
  logic [31:0]                    rdata_q;
  logic                           accept;
  logic                           cap_en;
  logic [BYTE_IDX_W-1:0]          cap_idx;
  logic                           unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.req_addr[BYTE_IDX_W-1:0];
  assign accept           = (state_q == IDLE) && bus.req_valid;

  // Ready is also gated by the raw reset so nothing is accepted while reset is held.
  assign bus.req_ready = (state_q == IDLE) && resetn;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;

  // cnt parks on the last byte after a transaction, so address/data outputs hold their last value.
  assign mem_ad    = {addr_q, cnt_q};
  assign mem_din   = wdata_q[{cnt_q, 3'b000} +: 8];
  assign mem_oce   = mem_ce;
  assign mem_reset = 1'b0;

  always_comb begin
    state_d = state_q;
    mem_ce  = 1'b0;
    mem_wre = 1'b0;
    cap_en  = 1'b0;
    cap_idx = cnt_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        mem_ce  = we_q ? wstrb_q[cnt_q] : 1'b1;
        mem_wre = we_q & wstrb_q[cnt_q];
        cap_en  = !we_q && (cnt_q != '0);
        if (cnt_q == LAST_IDX) state_d = we_q ? RESP : DRAIN;
      end
      DRAIN: begin
        cap_en  = 1'b1;
        cap_idx = LAST_IDX;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read byte k is presented by the RAM one edge after its access and captured one edge later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr[ADDR_W-1:BYTE_IDX_W];
        wdata_q <= bus.req_wdata;
        wstrb_q <= bus.req_wstrb;
      end else if ((state_q == ACCESS) && (cnt_q != LAST_IDX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cap_en) rdata_q[{cap_idx, 3'b000} +: 8] <= mem_dout;
    end
  end

endmodule
